// File: rtl/mfm_write_encoder_pkg.sv
// Shared definitions for the floppy MFM write path: state encodings, sync/gap
// constants and default cell timing (also used by the read-side decoder).
package mfm_write_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } wr_state_t;

    localparam logic [15:0] MFM_SYNC_A1 = 16'h4489;
    localparam logic [7:0]  SYNC_BYTE   = 8'hA1;
    localparam logic [7:0]  GAP_BYTE    = 8'h4E;

    localparam int DEF_CLKS_PER_CELL = 100;
    localparam int DEF_PULSE_CLKS    = 25;
    localparam int DEF_LEAD_CELLS    = 16;
    localparam int CELLS_PER_BYTE    = 16;

endpackage

// File: rtl/mfm_bit_encoder.sv
// Combinational MFM encoder: one byte plus the previous data bit becomes a
// 16-cell word (clock/data pairs, MSB first) and the new previous bit.
module mfm_bit_encoder
    import mfm_write_encoder_pkg::*;
(
    input  logic [7:0]  data,
    input  logic        mark,
    input  logic        prev_in,
    output logic [15:0] cells,
    output logic        prev_out
);

    logic [8:0]  prev_chain;
    logic [15:0] plain_cells;
    logic        sync_hit;

    assign prev_chain[0] = prev_in;

    // Clock cell is set only between two zero data bits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign plain_cells[15 - 2*gi] = ~prev_chain[gi] & ~data[7 - gi];
            assign plain_cells[14 - 2*gi] = data[7 - gi];
            assign prev_chain[gi + 1]     = data[7 - gi];
        end
    endgenerate

    // The sync mark deliberately drops one clock cell, so it cannot come from the rule above.
    assign sync_hit = mark && (data == SYNC_BYTE);
    assign cells    = sync_hit ? MFM_SYNC_A1 : plain_cells;
    assign prev_out = sync_hit ? 1'b1 : prev_chain[8];

endmodule

// File: rtl/mfm_write_encoder.sv
// MFM write encoder: one-byte holding buffer, lead-in, cell timing, write-pulse
// generation, gap-byte fill on underrun and write-gate control.
module mfm_write_encoder
    import mfm_write_encoder_pkg::*;
#(
    parameter int         CLKS_PER_CELL = DEF_CLKS_PER_CELL,
    parameter int         PULSE_CLKS    = DEF_PULSE_CLKS,
    parameter int         LEAD_CELLS    = DEF_LEAD_CELLS,
    parameter logic [7:0] FILL_BYTE     = GAP_BYTE
) (
    input  logic       clk,
    input  logic       RESET_IN,
    input  logic       enable,
    input  logic [7:0] byte_in,
    input  logic       byte_mark,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       underrun,
    output logic       busy,
    output logic       wgate_n,
    output logic       wdata_n
);

    localparam int CNT_W = $clog2(CLKS_PER_CELL);
    localparam int IDX_W = $clog2((LEAD_CELLS > CELLS_PER_BYTE) ? LEAD_CELLS : CELLS_PER_BYTE);
    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(CLKS_PER_CELL - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CLKS);
    localparam logic [IDX_W-1:0] LEAD_LAST = IDX_W'(LEAD_CELLS - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(CELLS_PER_BYTE - 1);

    wr_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cell_cnt_reg;
    logic [IDX_W-1:0] cell_idx_reg;
    logic [15:0]      cells_reg;
    logic             prev_reg;
    logic [7:0]       buf_data_reg;
    logic             buf_mark_reg;
    logic             buf_full_reg;
    logic             underrun_reg;

    logic        cell_end, boundary, load, load_fill, drain_now, take;
    logic [7:0]  enc_data;
    logic        enc_mark, enc_prev, enc_prev_out;
    logic [15:0] enc_cells;

    assign cell_end  = (cell_cnt_reg == CELL_LAST);
    assign boundary  = cell_end &&
                       (((state_reg == ST_LEAD)  && (cell_idx_reg == LEAD_LAST)) ||
                        ((state_reg == ST_SHIFT) && (cell_idx_reg == BYTE_LAST)));
    assign load      = boundary && enable;
    assign load_fill = load && !buf_full_reg;
    assign drain_now = boundary && !enable;
    assign take      = byte_valid && byte_ready;

    // The first byte after the lead-in always starts from prev = 0.
    assign enc_data = buf_full_reg ? buf_data_reg : FILL_BYTE;
    assign enc_mark = buf_full_reg && buf_mark_reg;
    assign enc_prev = (state_reg == ST_LEAD) ? 1'b0 : prev_reg;

    mfm_bit_encoder u_bit_encoder (
        .data     (enc_data),
        .mark     (enc_mark),
        .prev_in  (enc_prev),
        .cells    (enc_cells),
        .prev_out (enc_prev_out)
    );

    always_ff @(posedge clk or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_reg    <= ST_IDLE;
            cell_cnt_reg <= '0;
            cell_idx_reg <= '0;
            cells_reg    <= '0;
            prev_reg     <= 1'b0;
            buf_data_reg <= '0;
            buf_mark_reg <= 1'b0;
            buf_full_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            underrun_reg <= load_fill;

            if (state_reg == ST_IDLE || cell_end)
                cell_cnt_reg <= '0;
            else
                cell_cnt_reg <= cell_cnt_reg + 1'b1;

            if (state_reg == ST_IDLE || state_reg == ST_DRAIN || boundary)
                cell_idx_reg <= '0;
            else if (cell_end)
                cell_idx_reg <= cell_idx_reg + 1'b1;

            if (load) begin
                cells_reg <= enc_cells;
                prev_reg  <= enc_prev_out;
            end else if (state_reg == ST_SHIFT && cell_end) begin
                cells_reg <= {cells_reg[14:0], 1'b0};
            end

            // A boundary always empties the buffer: consumed on load, discarded on drain.
            if (boundary)
                buf_full_reg <= 1'b0;
            if (take) begin
                buf_full_reg <= 1'b1;
                buf_data_reg <= byte_in;
                buf_mark_reg <= byte_mark;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (enable) state_next = ST_LEAD;
            ST_LEAD,
            ST_SHIFT: if (boundary) state_next = enable ? ST_SHIFT : ST_DRAIN;
            ST_DRAIN: if (cell_end) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg != ST_IDLE);
        wgate_n    = (state_reg == ST_IDLE);
        wdata_n    = !((state_reg == ST_SHIFT) && cells_reg[15] && (cell_cnt_reg < PULSE_END));
        byte_ready = !buf_full_reg && !drain_now &&
                     ((state_reg == ST_LEAD) || (state_reg == ST_SHIFT));
        underrun   = underrun_reg;
    end

endmodule
